// File: rtl/decode_stage_pipe_pkg.sv
// rtl/decode_stage_pipe_pkg.sv - shared types, opcodes and ex_ctrl bit positions for the decode stage
package decode_stage_pipe_pkg;

   localparam int LINK_REG_DEFAULT = 31;
   localparam int CTRL_W           = 11;

   localparam int CTRL_REGWRITE   = 10;
   localparam int CTRL_BRANCH     = 9;
   localparam int CTRL_MEMREAD    = 8;
   localparam int CTRL_MEMWRITE   = 7;
   localparam int CTRL_MEMTOREG   = 6;
   localparam int CTRL_JR         = 5;
   localparam int CTRL_MEM_SIGNED = 4;
   localparam int CTRL_MEMLEN_HI  = 3;
   localparam int CTRL_MEMLEN_LO  = 2;
   localparam int CTRL_LINK       = 1;
   localparam int CTRL_J          = 0;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FUNC_JR  = 6'h08;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_len_e;

   typedef struct packed {
      logic              regdst;
      logic              alusrc;
      logic              expand;
      logic [CTRL_W-1:0] ctrl;
   } dec_t;

   function automatic int ra_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

   function automatic logic [1:0] mem_len_of(input logic [5:0] op);
      case (op)
         OP_LH, OP_LHU, OP_SH: return MEM_HALF;
         OP_LW, OP_SW:         return MEM_WORD;
         default:              return MEM_BYTE;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - instruction, writeback and ID/EX handshake bundle of the decode stage
interface decode_stage_pipe_if #(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32
);
   localparam int RA = decode_stage_pipe_pkg::ra_width(REG_COUNT);
   localparam int CW = decode_stage_pipe_pkg::CTRL_W;

   logic            id_valid;
   logic            id_ready;
   logic [5:0]      op;
   logic [5:0]      func;
   logic [RA-1:0]   rs;
   logic [RA-1:0]   rt;
   logic [RA-1:0]   rd;
   logic [15:0]     imm;
   logic            wb_en;
   logic [RA-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            flush;
   logic            ex_ready;
   logic            ex_valid;
   logic [XLEN-1:0] ex_alu_data_1;
   logic [XLEN-1:0] ex_alu_data_2;
   logic [XLEN-1:0] ex_reg_data_2;
   logic [XLEN-1:0] ex_expand_imm;
   logic [RA-1:0]   ex_rw;
   logic [CW-1:0]   ex_ctrl;

   modport master (
      output id_valid, op, func, rs, rt, rd, imm,
      output wb_en, wb_addr, wb_data, flush, ex_ready,
      input  id_ready, ex_valid, ex_alu_data_1, ex_alu_data_2,
      input  ex_reg_data_2, ex_expand_imm, ex_rw, ex_ctrl
   );

   modport slave (
      input  id_valid, op, func, rs, rt, rd, imm,
      input  wb_en, wb_addr, wb_data, flush, ex_ready,
      output id_ready, ex_valid, ex_alu_data_1, ex_alu_data_2,
      output ex_reg_data_2, ex_expand_imm, ex_rw, ex_ctrl
   );

endinterface

// File: rtl/controller.sv
// rtl/controller.sv - opcode/function decode into datapath selects and ex_ctrl bits
module controller
   import decode_stage_pipe_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output dec_t       dec
);

   always_comb begin
      dec = '0;
      case (op)
         OP_RTYPE: begin
            if (func == FUNC_JR) begin
               dec.ctrl[CTRL_JR] = 1'b1;
            end else begin
               dec.regdst              = 1'b1;
               dec.ctrl[CTRL_REGWRITE] = 1'b1;
            end
         end
         OP_J: begin
            dec.ctrl[CTRL_J] = 1'b1;
         end
         OP_JAL: begin
            dec.ctrl[CTRL_REGWRITE] = 1'b1;
            dec.ctrl[CTRL_LINK]     = 1'b1;
            dec.ctrl[CTRL_J]        = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            dec.expand            = 1'b1;
            dec.ctrl[CTRL_BRANCH] = 1'b1;
         end
         OP_ADDI, OP_ADDIU: begin
            dec.alusrc              = 1'b1;
            dec.expand              = 1'b1;
            dec.ctrl[CTRL_REGWRITE] = 1'b1;
         end
         // logical immediates are zero-extended
         OP_ANDI, OP_ORI: begin
            dec.alusrc              = 1'b1;
            dec.ctrl[CTRL_REGWRITE] = 1'b1;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            dec.alusrc                                = 1'b1;
            dec.expand                                = 1'b1;
            dec.ctrl[CTRL_REGWRITE]                   = 1'b1;
            dec.ctrl[CTRL_MEMREAD]                    = 1'b1;
            dec.ctrl[CTRL_MEMTOREG]                   = 1'b1;
            dec.ctrl[CTRL_MEM_SIGNED]                 = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
            dec.ctrl[CTRL_MEMLEN_HI:CTRL_MEMLEN_LO]   = mem_len_of(op);
         end
         OP_SB, OP_SH, OP_SW: begin
            dec.alusrc                              = 1'b1;
            dec.expand                              = 1'b1;
            dec.ctrl[CTRL_MEMWRITE]                 = 1'b1;
            dec.ctrl[CTRL_MEMLEN_HI:CTRL_MEMLEN_LO] = mem_len_of(op);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - 2R1W register file, r0 hardwired to zero, write-first read bypass
module regfile_bypass #(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32,
   parameter int RA        = 5
)(
   input  logic            clock,
   input  logic            reset,
   input  logic [RA-1:0]   ra_1,
   input  logic [RA-1:0]   ra_2,
   output logic [XLEN-1:0] rd_1,
   output logic [XLEN-1:0] rd_2,
   input  logic            we,
   input  logic [RA-1:0]   wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [REG_COUNT];
   logic [RA-1:0]   ra   [2];
   logic [XLEN-1:0] rdat [2];

   assign ra[0] = ra_1;
   assign ra[1] = ra_2;
   assign rd_1  = rdat[0];
   assign rd_2  = rdat[1];

   // a write landing this cycle is visible to a same-cycle read
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdat[p] = '0;
         if (ra[p] == '0) begin
            rdat[p] = '0;
         end else if (we && (wa == ra[p])) begin
            rdat[p] = wd;
         end else if (int'(ra[p]) < REG_COUNT) begin
            rdat[p] = regs[ra[p]];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - pipelined decode stage: operand read, control decode, immediate extend, ID/EX register
module decode_stage_pipe
   import decode_stage_pipe_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32,
   parameter int LINK_REG  = LINK_REG_DEFAULT
)(
   input  logic              clock,
   input  logic              reset,
   decode_stage_pipe_if.slave bus
);

   localparam int            RA        = ra_width(REG_COUNT);
   localparam logic [RA-1:0] LINK_ADDR = RA'(LINK_REG);

   dec_t              dec;
   logic [XLEN-1:0]   rs_data;
   logic [XLEN-1:0]   rt_data;
   logic [XLEN-1:0]   expand_imm;
   logic [XLEN-1:0]   alu_data_2;
   logic [RA-1:0]     rw;
   logic [CTRL_W-1:0] ctrl;
   logic              advance;
   logic              hz;
   logic              accept;

   logic              ex_valid_q;
   logic [XLEN-1:0]   ex_alu_data_1_q;
   logic [XLEN-1:0]   ex_alu_data_2_q;
   logic [XLEN-1:0]   ex_reg_data_2_q;
   logic [XLEN-1:0]   ex_expand_imm_q;
   logic [RA-1:0]     ex_rw_q;
   logic [CTRL_W-1:0] ex_ctrl_q;

   controller u_ctrl (
      .op   (bus.op),
      .func (bus.func),
      .dec  (dec)
   );

   regfile_bypass #(
      .XLEN      (XLEN),
      .REG_COUNT (REG_COUNT),
      .RA        (RA)
   ) u_rf (
      .clock (clock),
      .reset (reset),
      .ra_1  (bus.rs),
      .ra_2  (bus.rt),
      .rd_1  (rs_data),
      .rd_2  (rt_data),
      .we    (bus.wb_en),
      .wa    (bus.wb_addr),
      .wd    (bus.wb_data)
   );

   assign rw         = dec.regdst ? bus.rd : (dec.ctrl[CTRL_LINK] ? LINK_ADDR : bus.rt);
   assign expand_imm = dec.expand ? {{(XLEN-16){bus.imm[15]}}, bus.imm}
                                  : {{(XLEN-16){1'b0}}, bus.imm};
   assign alu_data_2 = dec.alusrc ? expand_imm : rt_data;

   always_comb begin
      ctrl = dec.ctrl;
      if (rw == '0) begin
         ctrl[CTRL_REGWRITE] = 1'b0;
      end
   end

   // rt is compared even for instructions that do not read it
   assign hz = ex_valid_q && ex_ctrl_q[CTRL_MEMREAD] && (ex_rw_q != '0) &&
               ((ex_rw_q == bus.rs) || (ex_rw_q == bus.rt));

   assign advance      = !ex_valid_q || bus.ex_ready;
   assign bus.id_ready = reset && (bus.flush || (advance && !hz));
   assign accept       = bus.id_valid && bus.id_ready && !bus.flush;

   always_ff @(posedge clock) begin
      if (!reset) begin
         ex_valid_q      <= 1'b0;
         ex_alu_data_1_q <= '0;
         ex_alu_data_2_q <= '0;
         ex_reg_data_2_q <= '0;
         ex_expand_imm_q <= '0;
         ex_rw_q         <= '0;
         ex_ctrl_q       <= '0;
      end else if (bus.flush) begin
         ex_valid_q <= 1'b0;
         ex_ctrl_q  <= '0;
      end else if (advance) begin
         if (accept) begin
            ex_valid_q      <= 1'b1;
            ex_alu_data_1_q <= rs_data;
            ex_alu_data_2_q <= alu_data_2;
            ex_reg_data_2_q <= rt_data;
            ex_expand_imm_q <= expand_imm;
            ex_rw_q         <= rw;
            ex_ctrl_q       <= ctrl;
         end else begin
            // bubble: controls cleared, data fields left as they were
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
         end
      end
   end

   assign bus.ex_valid      = ex_valid_q;
   assign bus.ex_alu_data_1 = ex_alu_data_1_q;
   assign bus.ex_alu_data_2 = ex_alu_data_2_q;
   assign bus.ex_reg_data_2 = ex_reg_data_2_q;
   assign bus.ex_expand_imm = ex_expand_imm_q;
   assign bus.ex_rw         = ex_rw_q;
   assign bus.ex_ctrl       = ex_ctrl_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - self-checking bench for decode_stage_pipe
module tb_decode_stage_pipe;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   decode_stage_pipe_if #(.XLEN(32), .REG_COUNT(32)) bus();

   decode_stage_pipe #(.XLEN(32), .REG_COUNT(32), .LINK_REG(31)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference state: architectural registers and the ID/EX entry
   logic [31:0] m_rf [32];
   logic        m_valid;
   logic [10:0] m_ctrl;
   logic [4:0]  m_rw;
   logic [31:0] m_a1, m_a2, m_rd2, m_imm;

   // {regdst, alusrc, expand, ctrl[10:0]}
   function automatic logic [13:0] ref_decode(input logic [5:0] op, input logic [5:0] func);
      case (op)
         6'h00:        return (func == 6'h08) ? {3'b000, 11'h020} : {3'b100, 11'h400};
         6'h02:        return {3'b000, 11'h001};
         6'h03:        return {3'b000, 11'h403};
         6'h04, 6'h05: return {3'b001, 11'h200};
         6'h08, 6'h09: return {3'b011, 11'h400};
         6'h0C, 6'h0D: return {3'b010, 11'h400};
         6'h20:        return {3'b011, 11'h550};
         6'h21:        return {3'b011, 11'h554};
         6'h23:        return {3'b011, 11'h558};
         6'h24:        return {3'b011, 11'h540};
         6'h25:        return {3'b011, 11'h544};
         6'h28:        return {3'b011, 11'h080};
         6'h29:        return {3'b011, 11'h084};
         6'h2B:        return {3'b011, 11'h088};
         default:      return 14'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (bus.wb_en && (bus.wb_addr == a)) return bus.wb_data;
      return m_rf[a];
   endfunction

   function automatic logic m_ready();
      logic stall;
      if (!reset) return 1'b0;
      if (bus.flush) return 1'b1;
      stall = m_valid && m_ctrl[8] && (m_rw != 5'd0) && ((m_rw == bus.rs) || (m_rw == bus.rt));
      return (!m_valid || bus.ex_ready) && !stall;
   endfunction

   always @(posedge clock) begin
      logic [13:0] d;
      logic [4:0]  rw;
      logic        rdy;
      rdy = m_ready();
      if (!reset) begin
         m_valid = 1'b0;
         m_ctrl  = '0;
         m_rw    = '0;
         m_a1    = '0;
         m_a2    = '0;
         m_rd2   = '0;
         m_imm   = '0;
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
      end else begin
         if (bus.flush) begin
            m_valid = 1'b0;
            m_ctrl  = '0;
         end else if (!m_valid || bus.ex_ready) begin
            if (bus.id_valid && rdy) begin
               d       = ref_decode(bus.op, bus.func);
               rw      = d[13] ? bus.rd : (d[1] ? 5'd31 : bus.rt);
               m_valid = 1'b1;
               m_ctrl  = d[10:0];
               if (rw == 5'd0) m_ctrl[10] = 1'b0;
               m_rw    = rw;
               m_a1    = m_read(bus.rs);
               m_rd2   = m_read(bus.rt);
               m_imm   = d[11] ? {{16{bus.imm[15]}}, bus.imm} : {16'h0, bus.imm};
               m_a2    = d[12] ? m_imm : m_rd2;
            end else begin
               m_valid = 1'b0;
               m_ctrl  = '0;
            end
         end
         if (bus.wb_en && (bus.wb_addr != 5'd0)) m_rf[bus.wb_addr] = bus.wb_data;
      end
   end

   always @(negedge clock) begin
      check("cyc_ex_valid", 32'(bus.ex_valid), 32'(m_valid));
      check("cyc_id_ready", 32'(bus.id_ready), 32'(m_ready()));
      check("cyc_ex_ctrl", 32'(bus.ex_ctrl), 32'(m_ctrl));
      check("cyc_ex_rw", 32'(bus.ex_rw), 32'(m_rw));
      check("cyc_alu_data_1", bus.ex_alu_data_1, m_a1);
      check("cyc_alu_data_2", bus.ex_alu_data_2, m_a2);
      check("cyc_reg_data_2", bus.ex_reg_data_2, m_rd2);
      check("cyc_expand_imm", bus.ex_expand_imm, m_imm);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
      bus.op   = op;
      bus.func = func;
      bus.rs   = rs;
      bus.rt   = rt;
      bus.rd   = rd;
      bus.imm  = imm;
   endtask

   // returns one step after the instruction has been accepted
   task automatic send(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
      int waited;
      set_instr(op, func, rs, rt, rd, imm);
      bus.id_valid = 1'b1;
      waited = 0;
      @(negedge clock);
      while (!(bus.id_ready && !bus.flush) && (waited < 20)) begin
         waited++;
         @(negedge clock);
      end
      if (waited >= 20) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: id_ready low for %0d cycles, required 1", waited);
      end
      step();
      bus.id_valid = 1'b0;
   endtask

   initial begin
      bus.id_valid = 1'b1;
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b1;
      bus.wb_en    = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);

      // 1: reset with a valid instruction presented
      repeat (3) begin
         step();
         check("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
         check("rst_id_ready", 32'(bus.id_ready), 32'h0);
         check("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
      end
      reset        = 1'b1;
      bus.id_valid = 1'b0;
      step();
      for (int i = 1; i < 32; i++) begin
         send(6'h00, 6'h20, 5'(i), 5'(i), 5'd1, 16'h0);
         check("rst_reg_read", bus.ex_alu_data_1, 32'h0);
      end

      // 2: writeback bypass into the same-cycle decode
      bus.wb_en   = 1'b1;
      bus.wb_addr = 5'd5;
      bus.wb_data = 32'h0000_1234;
      send(6'h00, 6'h20, 5'd5, 5'd5, 5'd3, 16'h0);
      bus.wb_en = 1'b0;
      check("byp_alu_data_1", bus.ex_alu_data_1, 32'h0000_1234);
      check("byp_reg_data_2", bus.ex_reg_data_2, 32'h0000_1234);
      check("byp_ex_rw", 32'(bus.ex_rw), 32'd3);
      check("byp_ex_ctrl", 32'(bus.ex_ctrl), 32'h400);

      // 3: load-use stall inserts one bubble
      send(6'h23, 6'h00, 5'd0, 5'd7, 5'd0, 16'h0004);
      check("lw_ex_ctrl", 32'(bus.ex_ctrl), 32'h558);
      set_instr(6'h00, 6'h20, 5'd7, 5'd8, 5'd9, 16'h0);
      bus.id_valid = 1'b1;
      @(negedge clock);
      check("lu_id_ready", 32'(bus.id_ready), 32'h0);
      step();
      check("lu_bubble_valid", 32'(bus.ex_valid), 32'h0);
      check("lu_bubble_ctrl", 32'(bus.ex_ctrl), 32'h0);
      check("lu_bubble_rw_held", 32'(bus.ex_rw), 32'd7);
      step();
      bus.id_valid = 1'b0;
      check("lu_add_valid", 32'(bus.ex_valid), 32'h1);
      check("lu_add_rw", 32'(bus.ex_rw), 32'd9);

      // 4: backpressure holds the entry for four cycles
      send(6'h08, 6'h00, 5'd5, 5'd10, 5'd0, 16'h0007);
      bus.ex_ready = 1'b0;
      set_instr(6'h0D, 6'h00, 5'd5, 5'd11, 5'd0, 16'h00F0);
      bus.id_valid = 1'b1;
      repeat (4) begin
         step();
         check("bp_id_ready", 32'(bus.id_ready), 32'h0);
         check("bp_ex_valid", 32'(bus.ex_valid), 32'h1);
         check("bp_ex_rw", 32'(bus.ex_rw), 32'd10);
         check("bp_alu_data_2", bus.ex_alu_data_2, 32'h7);
      end
      bus.ex_ready = 1'b1;
      step();
      bus.id_valid = 1'b0;
      check("bp_ori_rw", 32'(bus.ex_rw), 32'd11);
      check("bp_ori_alu_data_2", bus.ex_alu_data_2, 32'h0000_00F0);
      check("bp_ori_alu_data_1", bus.ex_alu_data_1, 32'h0000_1234);

      // 5: flush during a load-use stall under backpressure
      send(6'h23, 6'h00, 5'd0, 5'd12, 5'd0, 16'h0000);
      bus.ex_ready = 1'b0;
      set_instr(6'h00, 6'h20, 5'd12, 5'd0, 5'd13, 16'h0);
      bus.id_valid = 1'b1;
      step();
      check("fl_stall_id_ready", 32'(bus.id_ready), 32'h0);
      bus.flush = 1'b1;
      #1;
      check("fl_id_ready", 32'(bus.id_ready), 32'h1);
      step();
      bus.flush    = 1'b0;
      bus.id_valid = 1'b0;
      bus.ex_ready = 1'b1;
      check("fl_ex_valid", 32'(bus.ex_valid), 32'h0);
      check("fl_ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
      step();
      check("fl_no_dup_valid", 32'(bus.ex_valid), 32'h0);
      check("fl_rw_held", 32'(bus.ex_rw), 32'd12);

      // 6: immediate extension, link destination, r0 behaviour
      send(6'h08, 6'h00, 5'd0, 5'd1, 5'd0, 16'h8000);
      check("imm_sext", bus.ex_expand_imm, 32'hFFFF_8000);
      check("imm_sext_alu2", bus.ex_alu_data_2, 32'hFFFF_8000);
      send(6'h0D, 6'h00, 5'd0, 5'd1, 5'd0, 16'h8000);
      check("imm_zext", bus.ex_expand_imm, 32'h0000_8000);
      send(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0010);
      check("jal_rw", 32'(bus.ex_rw), 32'd31);
      check("jal_ctrl", 32'(bus.ex_ctrl), 32'h403);
      send(6'h08, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0001);
      check("rw0_ctrl", 32'(bus.ex_ctrl), 32'h0);
      bus.wb_en   = 1'b1;
      bus.wb_addr = 5'd0;
      bus.wb_data = 32'h0000_DEAD;
      send(6'h00, 6'h20, 5'd0, 5'd0, 5'd2, 16'h0);
      bus.wb_en = 1'b0;
      check("r0_no_bypass", bus.ex_alu_data_1, 32'h0);
      send(6'h00, 6'h20, 5'd0, 5'd0, 5'd2, 16'h0);
      check("r0_no_write", bus.ex_reg_data_2, 32'h0);
      send(6'h2B, 6'h00, 5'd5, 5'd5, 5'd0, 16'h0008);
      check("sw_store_data", bus.ex_reg_data_2, 32'h0000_1234);
      check("sw_ctrl", 32'(bus.ex_ctrl), 32'h088);

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
